day8_pair_gen: RTL and testbench

Streams every unordered box pair (s, d) with s < d as a squared-Euclidean-distance item {dist_sq, s, d}, one item per clock under valid/ready backpressure. It sits directly upstream of the day-8 pair sorter / circuit-connect stage and replaces the simulation-time distance table with synthesizable RTL. Box coordinates are written in through a load port. The pair stream is then generated by a 4-stage pipelined arithmetic path.

---
 rtl/day8_pair_gen.sv | 270 +++++++++++++++++++++++++++
 tb/tb_day8_pair_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/day8_pair_gen.sv
// Streams every box pair (s, d), s < d, with its squared Euclidean distance.
// Coordinates are loaded while idle; pairs flow through a 4-stage stallable pipeline.
module day8_pair_gen #(
  parameter int NUM_ELEMENTS     = 1000,
  parameter int INDEX_WIDTH      = 10,
  parameter int COORDINATE_WIDTH = 17,
  parameter int DISTANCE_WIDTH   = 36
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      load_valid,
  input  logic [INDEX_WIDTH-1:0]                    load_index,
  input  logic [COORDINATE_WIDTH-1:0]               load_x,
  input  logic [COORDINATE_WIDTH-1:0]               load_y,
  input  logic [COORDINATE_WIDTH-1:0]               load_z,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [DISTANCE_WIDTH+2*INDEX_WIDTH-1:0]   out_item,
  output logic                                      out_last,
  output logic                                      done
);

  localparam int CW        = COORDINATE_WIDTH;
  localparam int IW        = INDEX_WIDTH;
  localparam int DW        = DISTANCE_WIDTH;
  localparam int DIFF_W    = CW + 1;
  localparam int SQ_W      = 2 * CW + 2;
  localparam int ITEM_W    = DW + 2 * IW;
  localparam int MEM_DEPTH = 1 << IW;

  localparam logic [IW:0]   N_EXT  = (IW + 1)'(NUM_ELEMENTS);
  localparam logic [IW-1:0] LAST_S = IW'(NUM_ELEMENTS - 2);
  localparam logic [IW-1:0] LAST_D = IW'(NUM_ELEMENTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e state_q, state_d;
  logic [IW-1:0] s_q, s_d, d_q, d_d;
  logic          done_q, done_d;

  // Coordinate memory: intentionally not reset, contents persist across runs.
  logic [CW-1:0] mem_x [MEM_DEPTH];
  logic [CW-1:0] mem_y [MEM_DEPTH];
  logic [CW-1:0] mem_z [MEM_DEPTH];
  logic          mem_wr;

  // Stage 1: coordinate reads
  logic          s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [IW-1:0] s1_src_q, s1_src_d, s1_dst_q, s1_dst_d;
  logic [CW-1:0] s1_xa_q, s1_xa_d, s1_xb_q, s1_xb_d;
  logic [CW-1:0] s1_ya_q, s1_ya_d, s1_yb_q, s1_yb_d;
  logic [CW-1:0] s1_za_q, s1_za_d, s1_zb_q, s1_zb_d;

  // Stage 2: signed differences
  logic                     s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic [IW-1:0]            s2_src_q, s2_src_d, s2_dst_q, s2_dst_d;
  logic signed [DIFF_W-1:0] s2_dx_q, s2_dx_d, s2_dy_q, s2_dy_d, s2_dz_q, s2_dz_d;

  // Stage 3: squares
  logic            s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
  logic [IW-1:0]   s3_src_q, s3_src_d, s3_dst_q, s3_dst_d;
  logic [SQ_W-1:0] s3_sqx_q, s3_sqx_d, s3_sqy_q, s3_sqy_d, s3_sqz_q, s3_sqz_d;
  logic signed [SQ_W-1:0] dx_ext, dy_ext, dz_ext;

  // Stage 4: output register
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [ITEM_W-1:0] out_item_q, out_item_d;
  logic [DW-1:0]     dist_sum;

  logic advance, issue, pair_last, last_accept;

  assign advance     = !out_valid_q || out_ready;
  assign issue       = (state_q == RUN) && advance;
  assign pair_last   = (s_q == LAST_S) && (d_q == LAST_D);
  assign last_accept = out_valid_q && out_ready && out_last_q;
  assign mem_wr      = (state_q == IDLE) && load_valid && ({1'b0, load_index} < N_EXT);

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_x[load_index] <= load_x;
      mem_y[load_index] <= load_y;
      mem_z[load_index] <= load_z;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    d_d     = d_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          d_d     = IW'(1);
        end
      end
      RUN: begin
        if (issue) begin
          if (pair_last) begin
            state_d = DRAIN;
          end else if (d_q == LAST_D) begin
            s_d = s_q + IW'(1);
            d_d = s_q + IW'(2);
          end else begin
            d_d = d_q + IW'(1);
          end
        end
      end
      DRAIN: begin
        if (last_accept) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_src_d   = s1_src_q;
    s1_dst_d   = s1_dst_q;
    s1_xa_d    = s1_xa_q;
    s1_xb_d    = s1_xb_q;
    s1_ya_d    = s1_ya_q;
    s1_yb_d    = s1_yb_q;
    s1_za_d    = s1_za_q;
    s1_zb_d    = s1_zb_q;
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    s2_src_d   = s2_src_q;
    s2_dst_d   = s2_dst_q;
    s2_dx_d    = s2_dx_q;
    s2_dy_d    = s2_dy_q;
    s2_dz_d    = s2_dz_q;
    s3_valid_d = s3_valid_q;
    s3_last_d  = s3_last_q;
    s3_src_d   = s3_src_q;
    s3_dst_d   = s3_dst_q;
    s3_sqx_d   = s3_sqx_q;
    s3_sqy_d   = s3_sqy_q;
    s3_sqz_d   = s3_sqz_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_item_d  = out_item_q;

    dx_ext   = SQ_W'(s2_dx_q);
    dy_ext   = SQ_W'(s2_dy_q);
    dz_ext   = SQ_W'(s2_dz_q);
    dist_sum = DW'(s3_sqx_q) + DW'(s3_sqy_q) + DW'(s3_sqz_q);

    if (advance) begin
      // The counter keeps pointing at the last pair in DRAIN, so last is qualified by issue.
      s1_valid_d = issue;
      s1_last_d  = issue && pair_last;
      s1_src_d   = s_q;
      s1_dst_d   = d_q;
      s1_xa_d    = mem_x[s_q];
      s1_xb_d    = mem_x[d_q];
      s1_ya_d    = mem_y[s_q];
      s1_yb_d    = mem_y[d_q];
      s1_za_d    = mem_z[s_q];
      s1_zb_d    = mem_z[d_q];

      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      s2_src_d   = s1_src_q;
      s2_dst_d   = s1_dst_q;
      s2_dx_d    = $signed({1'b0, s1_xa_q}) - $signed({1'b0, s1_xb_q});
      s2_dy_d    = $signed({1'b0, s1_ya_q}) - $signed({1'b0, s1_yb_q});
      s2_dz_d    = $signed({1'b0, s1_za_q}) - $signed({1'b0, s1_zb_q});

      s3_valid_d = s2_valid_q;
      s3_last_d  = s2_last_q;
      s3_src_d   = s2_src_q;
      s3_dst_d   = s2_dst_q;
      s3_sqx_d   = $unsigned(dx_ext * dx_ext);
      s3_sqy_d   = $unsigned(dy_ext * dy_ext);
      s3_sqz_d   = $unsigned(dz_ext * dz_ext);

      out_valid_d = s3_valid_q;
      out_last_d  = s3_last_q;
      out_item_d  = {dist_sum, s3_src_q, s3_dst_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      d_q         <= '0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_src_q    <= '0;
      s1_dst_q    <= '0;
      s1_xa_q     <= '0;
      s1_xb_q     <= '0;
      s1_ya_q     <= '0;
      s1_yb_q     <= '0;
      s1_za_q     <= '0;
      s1_zb_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_src_q    <= '0;
      s2_dst_q    <= '0;
      s2_dx_q     <= '0;
      s2_dy_q     <= '0;
      s2_dz_q     <= '0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      s3_src_q    <= '0;
      s3_dst_q    <= '0;
      s3_sqx_q    <= '0;
      s3_sqy_q    <= '0;
      s3_sqz_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_item_q  <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      d_q         <= d_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_src_q    <= s1_src_d;
      s1_dst_q    <= s1_dst_d;
      s1_xa_q     <= s1_xa_d;
      s1_xb_q     <= s1_xb_d;
      s1_ya_q     <= s1_ya_d;
      s1_yb_q     <= s1_yb_d;
      s1_za_q     <= s1_za_d;
      s1_zb_q     <= s1_zb_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      s2_src_q    <= s2_src_d;
      s2_dst_q    <= s2_dst_d;
      s2_dx_q     <= s2_dx_d;
      s2_dy_q     <= s2_dy_d;
      s2_dz_q     <= s2_dz_d;
      s3_valid_q  <= s3_valid_d;
      s3_last_q   <= s3_last_d;
      s3_src_q    <= s3_src_d;
      s3_dst_q    <= s3_dst_d;
      s3_sqx_q    <= s3_sqx_d;
      s3_sqy_q    <= s3_sqy_d;
      s3_sqz_q    <= s3_sqz_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_item_q  <= out_item_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_item  = out_item_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_day8_pair_gen.sv
// Directed bench for day8_pair_gen at N=4: ordering, latency, backpressure,
// mid-run reset and ignored controls.
module tb_day8_pair_gen;

  localparam int N      = 4;
  localparam int IW     = 4;
  localparam int CW     = 17;
  localparam int DW     = 36;
  localparam int ITEM_W = DW + 2 * IW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_valid = 1'b0;
  logic [IW-1:0]     load_index = '0;
  logic [CW-1:0]     load_x = '0;
  logic [CW-1:0]     load_y = '0;
  logic [CW-1:0]     load_z = '0;
  logic              start = 1'b0;
  logic              busy;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ITEM_W-1:0] out_item;
  logic              out_last;
  logic              done;

  int errors = 0;
  int checks = 0;
  logic [ITEM_W-1:0] exp_items [6];

  day8_pair_gen #(
    .NUM_ELEMENTS(N),
    .INDEX_WIDTH(IW),
    .COORDINATE_WIDTH(CW),
    .DISTANCE_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_valid(load_valid),
    .load_index(load_index),
    .load_x(load_x),
    .load_y(load_y),
    .load_z(load_z),
    .start(start),
    .busy(busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_item(out_item),
    .out_last(out_last),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int idx, input int x, input int y, input int z);
    load_valid = 1'b1;
    load_index = IW'(idx);
    load_x     = CW'(x);
    load_y     = CW'(y);
    load_z     = CW'(z);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("wait_valid", 64'(out_valid), 1);
  endtask

  // mode 0: ready high, 1: toggle starting high, 2: random
  task automatic collect(input int mode, input string tag);
    int idx = 0;
    int cyc = 0;
    bit tog = 1'b1;
    bit seen_done = 1'b0;
    while (!seen_done && cyc < 80) begin
      case (mode)
        0: out_ready = 1'b1;
        1: begin out_ready = tog; tog = !tog; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (done) begin
        seen_done = 1'b1;
      end else if (out_valid) begin
        if (idx < 6) begin
          check({tag, "_item"}, 64'(out_item), 64'(exp_items[idx]));
          check({tag, "_last"}, 64'(out_last), 64'(idx == 5));
        end else begin
          check({tag, "_overrun"}, 64'(idx), 5);
        end
        if (out_ready) idx++;
      end
      if (!seen_done) tick();
      cyc++;
    end
    check({tag, "_done_seen"}, 64'(seen_done), 1);
    check({tag, "_count"}, 64'(idx), 6);
    check({tag, "_busy_at_done"}, 64'(busy), 0);
    out_ready = 1'b1;
    tick();
    check({tag, "_done_pulse"}, 64'(done), 0);
  endtask

  initial begin
    exp_items[0] = {36'd9,           4'd0, 4'd1};
    exp_items[1] = {36'd25,          4'd0, 4'd2};
    exp_items[2] = {36'd17179607041, 4'd0, 4'd3};
    exp_items[3] = {36'd12,          4'd1, 4'd2};
    exp_items[4] = {36'd17179344908, 4'd1, 4'd3};
    exp_items[5] = {36'd17178820640, 4'd2, 4'd3};

    // reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_item", 64'(out_item), 0);
    check("rst_out_last", 64'(out_last), 0);
    check("rst_done", 64'(done), 0);
    check("rst_busy", 64'(busy), 0);

    load(0, 0, 0, 0);
    load(1, 1, 2, 2);
    load(2, 3, 0, 4);
    load(3, 131071, 0, 0);

    // latency and full-rate stream
    out_ready = 1'b1;
    do_start();
    check("lat_busy", 64'(busy), 1);
    check("lat_e0_valid", 64'(out_valid), 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("lat_early_valid", 64'(out_valid), 0);
    end
    tick();
    check("lat_e4_valid", 64'(out_valid), 1);
    for (int k = 0; k < 6; k++) begin
      check("tp_valid", 64'(out_valid), 1);
      check("tp_item", 64'(out_item), 64'(exp_items[k]));
      check("tp_last", 64'(out_last), 64'(k == 5));
      check("tp_done_early", 64'(done), 0);
      tick();
    end
    check("tp_done", 64'(done), 1);
    check("tp_busy_fall", 64'(busy), 0);
    check("tp_valid_after", 64'(out_valid), 0);
    tick();
    check("tp_done_single", 64'(done), 0);

    // backpressure: 3 stalled cycles, then alternating ready
    out_ready = 1'b0;
    do_start();
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_item", 64'(out_item), 64'(exp_items[0]));
      check("bp_hold_valid", 64'(out_valid), 1);
      tick();
    end
    collect(1, "bp");

    // reset mid-run after two handshakes
    out_ready = 1'b1;
    do_start();
    wait_valid();
    check("mr_item0", 64'(out_item), 64'(exp_items[0]));
    tick();
    check("mr_item1", 64'(out_item), 64'(exp_items[1]));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_valid", 64'(out_valid), 0);
    check("mr_busy", 64'(busy), 0);
    check("mr_done", 64'(done), 0);
    tick();
    check("mr_done_late", 64'(done), 0);
    check("mr_valid_late", 64'(out_valid), 0);
    do_start();
    collect(0, "mr_replay");

    // start and load pulsed during RUN are ignored
    do_start();
    start      = 1'b1;
    load_valid = 1'b1;
    load_index = IW'(1);
    load_x     = '0;
    load_y     = '0;
    load_z     = '0;
    tick();
    tick();
    start      = 1'b0;
    load_valid = 1'b0;
    collect(0, "ign_run");

    // out-of-range load index in IDLE must not alias any box
    load(7, 0, 0, 0);
    do_start();
    collect(0, "ign_idx");

    // random backpressure
    do_start();
    collect(2, "rnd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
